// File: rtl/axi_lite_sram_slave_pkg.sv
// Shared AXI4-Lite definitions for the on-chip SRAM responder:
// response codes, default bus widths and channel FSM state types.
package axi_lite_sram_slave_pkg;

  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

endpackage

// File: rtl/axi_lite_sram_slave_sram_bwe.sv
// Word-addressed SRAM with one synchronous byte-enabled write port and one
// asynchronous read port; contents are not reset.
module sram_bwe #(
  parameter int WORDS     = 16384,
  parameter int DATA_BITS = 32,
  parameter int IDX_BITS  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                   ACLK,
  input  logic [DATA_BITS/8-1:0] wr_be,
  input  logic [IDX_BITS-1:0]    wr_idx,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic [IDX_BITS-1:0]    rd_idx,
  output logic [DATA_BITS-1:0]   rd_data
);

  logic [DATA_BITS-1:0] mem [WORDS];

  always_ff @(posedge ACLK) begin
    for (int b = 0; b < DATA_BITS/8; b++) begin
      if (wr_be[b]) begin
        mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder in front of a byte-writable SRAM. Independent read and
// write channels, one outstanding transaction each, all outputs registered.
module axi_lite_sram_slave
  import axi_lite_sram_slave_pkg::*;
#(
  parameter int                   ADDR_BITS = AXI_ADDR_BITS,
  parameter int                   DATA_BITS = AXI_DATA_BITS,
  parameter int                   MEM_WORDS = 16384,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [ADDR_BITS-1:0]   ARADDR_S,
  input  logic                   ARVALID_S,
  output logic                   ARREADY_S,
  output logic [DATA_BITS-1:0]   RDATA_S,
  output logic [1:0]             RRESP_S,
  output logic                   RVALID_S,
  input  logic                   RREADY_S,
  input  logic [ADDR_BITS-1:0]   AWADDR_S,
  input  logic                   AWVALID_S,
  output logic                   AWREADY_S,
  input  logic [DATA_BITS-1:0]   WDATA_S,
  input  logic [DATA_BITS/8-1:0] WSTRB_S,
  input  logic                   WVALID_S,
  output logic                   WREADY_S,
  output logic [1:0]             BRESP_S,
  output logic                   BVALID_S,
  input  logic                   BREADY_S
);

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int IDX_BITS  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr);
    logic [ADDR_BITS-1:0] offset;
    offset = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((offset >> 2) < ADDR_BITS'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_BITS-1:0] word_index(input logic [ADDR_BITS-1:0] addr);
    logic [ADDR_BITS-1:0] offset;
    offset = addr - BASE_ADDR;
    return IDX_BITS'(offset >> 2);
  endfunction

  rd_state_e              rd_state_q, rd_state_d;
  logic                   ar_ready_q, ar_ready_d;
  logic                   r_valid_q, r_valid_d;
  logic [DATA_BITS-1:0]   r_data_q, r_data_d;
  logic [1:0]             r_resp_q, r_resp_d;

  wr_state_e              wr_state_q, wr_state_d;
  logic                   aw_ready_q, aw_ready_d;
  logic                   w_ready_q, w_ready_d;
  logic                   aw_held_q, aw_held_d;
  logic                   w_held_q, w_held_d;
  logic [ADDR_BITS-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_BITS-1:0]   w_data_q, w_data_d;
  logic [STRB_BITS-1:0]   w_strb_q, w_strb_d;
  logic                   b_valid_q, b_valid_d;
  logic [1:0]             b_resp_q, b_resp_d;

  logic [STRB_BITS-1:0]   mem_be;
  logic [IDX_BITS-1:0]    mem_wr_idx;
  logic [DATA_BITS-1:0]   mem_wr_data;
  logic [DATA_BITS-1:0]   mem_rd_data;

  sram_bwe #(
    .WORDS     (MEM_WORDS),
    .DATA_BITS (DATA_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_sram (
    .ACLK    (ACLK),
    .wr_be   (mem_be),
    .wr_idx  (mem_wr_idx),
    .wr_data (mem_wr_data),
    .rd_idx  (word_index(ARADDR_S)),
    .rd_data (mem_rd_data)
  );

  // The asynchronous read port means a same-edge write is not yet visible here.
  always_comb begin
    rd_state_d = rd_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (rd_state_q)
      RD_IDLE: begin
        ar_ready_d = 1'b1;
        if (ARVALID_S && ar_ready_q) begin
          ar_ready_d = 1'b0;
          r_valid_d  = 1'b1;
          r_data_d   = addr_in_range(ARADDR_S) ? mem_rd_data : '0;
          r_resp_d   = addr_in_range(ARADDR_S) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (RREADY_S) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Commit happens on the edge where both halves are held (latched or handshaking now).
  always_comb begin
    wr_state_d  = wr_state_q;
    aw_ready_d  = aw_ready_q;
    w_ready_d   = w_ready_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;
    mem_be      = '0;
    mem_wr_idx  = '0;
    mem_wr_data = '0;
    case (wr_state_q)
      WR_IDLE: begin
        if (AWVALID_S && aw_ready_q) begin
          aw_held_d = 1'b1;
          aw_addr_d = AWADDR_S;
        end
        if (WVALID_S && w_ready_q) begin
          w_held_d = 1'b1;
          w_data_d = WDATA_S;
          w_strb_d = WSTRB_S;
        end
        if (aw_held_d && w_held_d) begin
          mem_be      = addr_in_range(aw_addr_d) ? w_strb_d : '0;
          mem_wr_idx  = word_index(aw_addr_d);
          mem_wr_data = w_data_d;
          b_valid_d   = 1'b1;
          b_resp_d    = addr_in_range(aw_addr_d) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          aw_held_d   = 1'b0;
          w_held_d    = 1'b0;
          aw_ready_d  = 1'b0;
          w_ready_d   = 1'b0;
          wr_state_d  = WR_RESP;
        end else begin
          aw_ready_d = !aw_held_d;
          w_ready_d  = !w_held_d;
        end
      end
      WR_RESP: begin
        if (BREADY_S) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q <= RD_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= AXI_RESP_OKAY;
      wr_state_q <= WR_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= AXI_RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      wr_state_q <= wr_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
    end
  end

  assign ARREADY_S = ar_ready_q;
  assign RVALID_S  = r_valid_q;
  assign RDATA_S   = r_data_q;
  assign RRESP_S   = r_resp_q;
  assign AWREADY_S = aw_ready_q;
  assign WREADY_S  = w_ready_q;
  assign BVALID_S  = b_valid_q;
  assign BRESP_S   = b_resp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: a byte-level memory model feeds a
// response scoreboard that is drained as the slave returns R and B beats.
module tb_axi_lite_sram_slave;
  import axi_lite_sram_slave_pkg::*;

  localparam int          MEM_WORDS = 16384;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] ARADDR_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RVALID_S;
  logic        RREADY_S;
  logic [31:0] AWADDR_S;
  logic        AWVALID_S;
  logic        AWREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WVALID_S;
  logic        WREADY_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S;

  int          assert_count = 0;
  int          fail_count   = 0;
  logic [31:0] model_mem [int];
  rd_exp_t     rd_exp_q [$];
  logic [1:0]  wr_exp_q [$];

  axi_lite_sram_slave #(
    .ADDR_BITS (32),
    .DATA_BITS (32),
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ARADDR_S  (ARADDR_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .AWADDR_S  (AWADDR_S),
    .AWVALID_S (AWVALID_S),
    .AWREADY_S (AWREADY_S),
    .WDATA_S   (WDATA_S),
    .WSTRB_S   (WSTRB_S),
    .WVALID_S  (WVALID_S),
    .WREADY_S  (WREADY_S),
    .BRESP_S   (BRESP_S),
    .BVALID_S  (BVALID_S),
    .BREADY_S  (BREADY_S)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic in_window(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < 32'(MEM_WORDS * 4));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int bready_delay);
    logic [1:0] exp_resp;
    logic       aw_done, w_done, hs_aw, hs_w;
    int         cyc;
    if (in_window(addr)) begin
      logic [31:0] w;
      w = model_mem.exists(int'((addr - BASE_ADDR) >> 2)) ? model_mem[int'((addr - BASE_ADDR) >> 2)] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      model_mem[int'((addr - BASE_ADDR) >> 2)] = w;
      wr_exp_q.push_back(AXI_RESP_OKAY);
    end else begin
      wr_exp_q.push_back(AXI_RESP_SLVERR);
    end
    AWADDR_S  = addr;
    WDATA_S   = data;
    WSTRB_S   = strb;
    WVALID_S  = 1'b1;
    AWVALID_S = (aw_delay == 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      hs_aw = AWVALID_S && AWREADY_S;
      hs_w  = WVALID_S && WREADY_S;
      @(negedge ACLK);
      cyc++;
      if (hs_aw) begin
        AWVALID_S = 1'b0;
        aw_done   = 1'b1;
      end
      if (hs_w) begin
        WVALID_S = 1'b0;
        w_done   = 1'b1;
        if (!aw_done) begin
          checkOutput("wready_after_w", WREADY_S, 1'b0);
          checkOutput("bvalid_before_aw", BVALID_S, 1'b0);
        end
      end
      if (!aw_done && !AWVALID_S && cyc >= aw_delay) AWVALID_S = 1'b1;
    end
    checkOutput("b_latency", BVALID_S, 1'b1);
    checkOutput("awready_busy", AWREADY_S, 1'b0);
    exp_resp = wr_exp_q.pop_front();
    checkOutput("bresp", BRESP_S, exp_resp);
    for (int i = 0; i < bready_delay; i++) begin
      @(negedge ACLK);
      checkOutput("bvalid_hold", BVALID_S, 1'b1);
      checkOutput("bresp_hold", BRESP_S, exp_resp);
      checkOutput("awready_hold", AWREADY_S, 1'b0);
      checkOutput("wready_hold", WREADY_S, 1'b0);
    end
    BREADY_S = 1'b1;
    @(negedge ACLK);
    BREADY_S = 1'b0;
    checkOutput("bvalid_clear", BVALID_S, 1'b0);
    checkOutput("awready_back", AWREADY_S, 1'b1);
    checkOutput("wready_back", WREADY_S, 1'b1);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int rready_delay);
    rd_exp_t e;
    int      cyc;
    ARADDR_S  = addr;
    ARVALID_S = 1'b1;
    cyc = 0;
    while (!ARREADY_S && cyc < 50) begin
      @(negedge ACLK);
      cyc++;
    end
    checkOutput("arready", ARREADY_S, 1'b1);
    if (in_window(addr)) begin
      e.data = model_mem[int'((addr - BASE_ADDR) >> 2)];
      e.resp = AXI_RESP_OKAY;
    end else begin
      e.data = 32'h0;
      e.resp = AXI_RESP_SLVERR;
    end
    rd_exp_q.push_back(e);
    @(negedge ACLK);
    ARVALID_S = 1'b0;
    checkOutput("r_latency", RVALID_S, 1'b1);
    checkOutput("arready_busy", ARREADY_S, 1'b0);
    e = rd_exp_q.pop_front();
    checkOutput("rdata", RDATA_S, e.data);
    checkOutput("rresp", RRESP_S, e.resp);
    for (int i = 0; i < rready_delay; i++) begin
      @(negedge ACLK);
      checkOutput("rvalid_hold", RVALID_S, 1'b1);
      checkOutput("rdata_hold", RDATA_S, e.data);
      checkOutput("arready_hold", ARREADY_S, 1'b0);
    end
    RREADY_S = 1'b1;
    @(negedge ACLK);
    RREADY_S = 1'b0;
    checkOutput("rvalid_clear", RVALID_S, 1'b0);
    checkOutput("arready_back", ARREADY_S, 1'b1);
  endtask

  // All directed steps run in order from this single process.
  initial begin
    ARESETn   = 1'b0;
    ARADDR_S  = '0;
    ARVALID_S = 1'b0;
    RREADY_S  = 1'b0;
    AWADDR_S  = '0;
    AWVALID_S = 1'b0;
    WDATA_S   = '0;
    WSTRB_S   = '0;
    WVALID_S  = 1'b0;
    BREADY_S  = 1'b0;

    repeat (3) @(negedge ACLK);
    checkOutput("rst_arready", ARREADY_S, 1'b0);
    checkOutput("rst_awready", AWREADY_S, 1'b0);
    checkOutput("rst_wready", WREADY_S, 1'b0);
    checkOutput("rst_rvalid", RVALID_S, 1'b0);
    checkOutput("rst_bvalid", BVALID_S, 1'b0);
    checkOutput("rst_rdata", RDATA_S, 32'h0);
    checkOutput("rst_rresp", RRESP_S, AXI_RESP_OKAY);
    checkOutput("rst_bresp", BRESP_S, AXI_RESP_OKAY);
    ARESETn = 1'b1;
    @(negedge ACLK);
    checkOutput("post_rst_arready", ARREADY_S, 1'b1);
    checkOutput("post_rst_awready", AWREADY_S, 1'b1);
    checkOutput("post_rst_wready", WREADY_S, 1'b1);

    $display("[TB] step 1: simultaneous AW/W write then read");
    write_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    read_txn(32'h10, 0);
    read_txn(32'h13, 0);

    $display("[TB] step 2: W leads AW by 3 cycles");
    write_txn(32'h20, 32'h11223344, 4'hF, 3, 0);
    read_txn(32'h20, 0);

    $display("[TB] step 3: byte strobes");
    write_txn(32'h30, 32'hAABBCCDD, 4'hF, 0, 0);
    write_txn(32'h30, 32'h00000099, 4'b0001, 0, 0);
    read_txn(32'h30, 0);
    write_txn(32'h30, 32'hFFFFFFFF, 4'b0000, 0, 0);
    read_txn(32'h30, 0);

    $display("[TB] step 4: out-of-range access");
    write_txn(32'h0, 32'h01020304, 4'hF, 0, 0);
    write_txn(BASE_ADDR + 32'(MEM_WORDS * 4 - 4), 32'h5A5A1234, 4'hF, 0, 0);
    write_txn(BASE_ADDR + 32'(MEM_WORDS * 4), 32'hFFFFFFFF, 4'hF, 0, 0);
    read_txn(BASE_ADDR + 32'(MEM_WORDS * 4), 0);
    read_txn(BASE_ADDR + 32'(MEM_WORDS * 4 - 4), 0);
    read_txn(32'h0, 0);

    $display("[TB] step 5: ready back-pressure");
    read_txn(32'h10, 5);
    write_txn(32'h50, 32'hCAFEF00D, 4'hF, 0, 5);
    read_txn(32'h50, 0);

    $display("[TB] step 6: reset mid-transaction");
    ARADDR_S  = 32'h40;
    ARVALID_S = 1'b1;
    @(negedge ACLK);
    ARVALID_S = 1'b0;
    checkOutput("mid_rvalid", RVALID_S, 1'b1);
    AWADDR_S  = 32'h44;
    AWVALID_S = 1'b1;
    @(negedge ACLK);
    AWVALID_S = 1'b0;
    checkOutput("mid_awready", AWREADY_S, 1'b0);
    checkOutput("mid_wready", WREADY_S, 1'b1);
    #2;
    ARESETn = 1'b0;
    #1;
    checkOutput("async_rst_rvalid", RVALID_S, 1'b0);
    checkOutput("async_rst_bvalid", BVALID_S, 1'b0);
    checkOutput("async_rst_arready", ARREADY_S, 1'b0);
    checkOutput("async_rst_wready", WREADY_S, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    checkOutput("rerst_arready", ARREADY_S, 1'b1);
    checkOutput("rerst_awready", AWREADY_S, 1'b1);
    checkOutput("rerst_wready", WREADY_S, 1'b1);
    checkOutput("rerst_bvalid", BVALID_S, 1'b0);
    write_txn(32'h44, 32'h0BADF00D, 4'hF, 0, 0);
    read_txn(32'h44, 0);
    read_txn(32'h20, 0);

    repeat (2) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
